// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-stage multiply unit.
package exe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 operand forwarding mux; the unused select code falls back to the register file.
module operand_fwd_mux
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] reg_val_i,
  input  logic [DATA_W-1:0] mem_val_i,
  input  logic [DATA_W-1:0] wb_val_i,
  output logic [DATA_W-1:0] val_o
);

  always_comb begin
    case (sel_i)
      FWD_MEM: val_o = mem_val_i;
      FWD_WB:  val_o = wb_val_i;
      default: val_o = reg_val_i;
    endcase
  end

endmodule

// File: rtl/exe_mul_stage.sv
// Iterative shift-add MUL/MLA unit beside the single-cycle ALU, with its own EXE/MEM register.
module exe_mul_stage
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_ADDR_W     = 4,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned EARLY_TERM     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  mul_start,
  input  logic                  accumulate,
  input  logic                  set_flags,
  input  logic                  wb_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     val_Rn,
  input  logic [DATA_W-1:0]     val_Rm,
  input  logic [DATA_W-1:0]     val_Ra,
  input  logic [1:0]            fwd_sel_rn,
  input  logic [1:0]            fwd_sel_rm,
  input  logic [1:0]            fwd_sel_ra,
  input  logic [DATA_W-1:0]     MEM_wb_value,
  input  logic [DATA_W-1:0]     WB_wb_value,
  input  logic [3:0]            status_in,
  output logic                  busy,
  output logic                  wb_en_hazard,
  output logic [REG_ADDR_W-1:0] dest_hazard,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     mul_res_out,
  output logic                  status_w_en_out,
  output logic [3:0]            status_out
);

  localparam int unsigned STEPS = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  mul_state_t state_q, state_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wb_en_q, wb_en_d, set_flags_q, set_flags_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  c_q, c_d, v_q, v_d;

  logic                  valid_q, valid_d, wb_en_out_q, wb_en_out_d;
  logic                  status_w_en_q, status_w_en_d;
  logic [REG_ADDR_W-1:0] dest_out_q, dest_out_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [3:0]            status_q, status_d;

  logic [DATA_W-1:0] rn_fwd, rm_fwd, ra_fwd, partial, mplier_shift;

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rn (
    .sel_i(fwd_sel_rn), .reg_val_i(val_Rn), .mem_val_i(MEM_wb_value), .wb_val_i(WB_wb_value),
    .val_o(rn_fwd)
  );
  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rm (
    .sel_i(fwd_sel_rm), .reg_val_i(val_Rm), .mem_val_i(MEM_wb_value), .wb_val_i(WB_wb_value),
    .val_o(rm_fwd)
  );
  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_ra (
    .sel_i(fwd_sel_ra), .reg_val_i(val_Ra), .mem_val_i(MEM_wb_value), .wb_val_i(WB_wb_value),
    .val_o(ra_fwd)
  );

  // mcand * mplier[B-1:0] as a sum of shifted multiplicands, one per retired bit.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    wb_en_d       = wb_en_q;
    dest_d        = dest_q;
    set_flags_d   = set_flags_q;
    c_d           = c_q;
    v_d           = v_q;
    valid_d       = valid_q;
    wb_en_out_d   = wb_en_out_q;
    dest_out_d    = dest_out_q;
    res_d         = res_q;
    status_w_en_d = status_w_en_q;
    status_d      = status_q;

    // Bubble by default; data fields keep their last value.
    if (!freeze) begin
      valid_d       = 1'b0;
      wb_en_out_d   = 1'b0;
      status_w_en_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mul_start) begin
          mcand_d     = rn_fwd;
          mplier_d    = rm_fwd;
          acc_d       = accumulate ? ra_fwd : '0;
          cnt_d       = '0;
          wb_en_d     = wb_en_in;
          dest_d      = dest_in;
          set_flags_d = set_flags;
          c_d         = status_in[FLAG_C];
          v_d         = status_in[FLAG_V];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST || (EARLY_TERM != 0 && mplier_shift == '0)) state_d = DONE;
      end
      DONE: begin
        if (!freeze) begin
          valid_d          = 1'b1;
          wb_en_out_d      = wb_en_q;
          dest_out_d       = dest_q;
          res_d            = acc_q;
          status_w_en_d    = set_flags_q;
          status_d[FLAG_N] = acc_q[DATA_W-1];
          status_d[FLAG_Z] = (acc_q == '0);
          status_d[FLAG_C] = c_q;
          status_d[FLAG_V] = v_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d       = IDLE;
      valid_d       = 1'b0;
      wb_en_out_d   = 1'b0;
      status_w_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      wb_en_q       <= 1'b0;
      dest_q        <= '0;
      set_flags_q   <= 1'b0;
      c_q           <= 1'b0;
      v_q           <= 1'b0;
      valid_q       <= 1'b0;
      wb_en_out_q   <= 1'b0;
      dest_out_q    <= '0;
      res_q         <= '0;
      status_w_en_q <= 1'b0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      wb_en_q       <= wb_en_d;
      dest_q        <= dest_d;
      set_flags_q   <= set_flags_d;
      c_q           <= c_d;
      v_q           <= v_d;
      valid_q       <= valid_d;
      wb_en_out_q   <= wb_en_out_d;
      dest_out_q    <= dest_out_d;
      res_q         <= res_d;
      status_w_en_q <= status_w_en_d;
      status_q      <= status_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign wb_en_hazard    = busy & wb_en_q;
  assign dest_hazard     = dest_q;
  assign valid_out       = valid_q;
  assign wb_en_out       = wb_en_out_q;
  assign dest_out        = dest_out_q;
  assign mul_res_out     = res_q;
  assign status_w_en_out = status_w_en_q;
  assign status_out      = status_q;

endmodule

// File: doc/exe_mul_stage.md
Name: exe_mul_stage

Overview:
Multi-cycle execute-stage unit for MUL/MLA. It runs in parallel with the single-cycle ALU execute path. It samples forwarded operands on the issue cycle and runs an iterative shift-add multiply that retires BITS_PER_CYCLE multiplier bits per cycle. While iterating it stalls the front of the pipeline through `busy`. It drives its own EXE/MEM output register with freeze and flush, and updates the status flags on set-flags instructions.

Parameters:
- DATA_W, 32: operand and result width; result is the low DATA_W bits.
- REG_ADDR_W, 4: destination register index width.
- BITS_PER_CYCLE, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4, and the value must divide DATA_W.
- EARLY_TERM, 0: if 1, finish as soon as the remaining multiplier bits are zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- freeze  in  1  hold the output register and the DONE state (MEM-side stall).
- flush  in  1  abort the in-flight operation and bubble the output register.
- mul_start  in  1  ID/EXE presents a MUL/MLA this cycle.
- accumulate  in  1  MLA: add Ra.
- set_flags  in  1  S bit.
- wb_en_in  in  1  instruction writes back.
- dest_in  in  REG_ADDR_W  destination register.
- val_Rn, val_Rm, val_Ra  in  DATA_W  register-file operands. Rn is the multiplicand, Rm is the multiplier.
- fwd_sel_rn, fwd_sel_rm, fwd_sel_ra  in  2  00 reg file, 01 MEM_wb_value, 10 WB_wb_value, 11 treated as 00.
- MEM_wb_value, WB_wb_value  in  DATA_W  forwarding sources.
- status_in  in  4  current NZCV.
- busy  out  1  state != IDLE; the hazard unit freezes IF/ID and ID/EXE.
- wb_en_hazard  out  1  combinational: (state != IDLE) & captured wb_en.
- dest_hazard  out  REG_ADDR_W  combinational: captured dest.
- valid_out  out  1  registered; result present in EXE/MEM.
- wb_en_out  out  1  registered.
- dest_out  out  REG_ADDR_W  registered.
- mul_res_out  out  DATA_W  registered result.
- status_w_en_out  out  1  registered.
- status_out  out  4  registered NZCV.

Behaviour:
- Reset: rst low clears every register and output to 0 immediately and forces state to IDLE. This applies mid-operation too.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Trigger: mul_start & !flush.
  - Capture: forwarded Rn into mcand and forwarded Rm into mplier. Initialise acc to forwarded Ra if accumulate, else 0.
  - Also capture wb_en, dest, set_flags and status_in C/V.
  - Set cnt=0, then go to BUSY.
  - Operands are sampled only on this cycle; later changes on the forwarding sources are ignored.
- BUSY, per cycle:
  - acc += mcand * mplier[B-1:0], where B = BITS_PER_CYCLE, truncated to DATA_W.
  - mcand <<= B; mplier >>= B; cnt++.
  - Go to DONE when cnt == DATA_W/B - 1, or when EARLY_TERM=1 and the shifted mplier == 0.
  - Otherwise stay in BUSY.
- Latency with EARLY_TERM=0: N = DATA_W/B BUSY cycles, then 1 DONE cycle. valid_out is high in cycle N+2 relative to the mul_start cycle 0.
- DONE & !freeze: load the output register and go to IDLE.
  - valid_out=1, wb_en_out=wb_en_q, dest_out=dest_q, mul_res_out=acc, status_w_en_out=set_flags_q.
  - status_out = {acc[DATA_W-1], acc==0, C_q, V_q}; C and V are preserved.
- DONE & freeze: stay in DONE; busy stays high; the output register holds.
- Output register in any other cycle: if !freeze, load a bubble (valid_out, wb_en_out and status_w_en_out set to 0; data fields hold their value). If freeze, hold.
- flush:
  - Dominates freeze.
  - Next state is IDLE from any state.
  - The output register loads a bubble.
  - Nothing is committed.
- mul_start while busy: ignored; upstream is frozen. The bench asserts it never occurs.
- Counter width: $clog2(DATA_W/B + 1).
- No signed or long multiplies; the low DATA_W bits are sign-agnostic.

Decomposition:
- Shared package exe_pkg contains:
  - mul_state_t enum (IDLE/BUSY/DONE);
  - FWD_REG/FWD_MEM/FWD_WB constants;
  - flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module, operand_fwd_mux: a 3:1 forwarding mux, parametrised by DATA_W and instantiated three times.

Test Plan:
- B=1, EARLY_TERM=0, Rn=7, Rm=6, dest=3, wb_en=1 -> busy for 33 cycles; valid_out pulses once at cycle 34 with mul_res_out=42, dest_out=3, wb_en_out=1.
- MLA: Rn=0xFFFFFFFF, Rm=2, Ra=100, S=1, status_in=0011 -> mul_res_out=0x00000062, status_w_en_out=1, status_out=0011.
- Forwarding: fwd_sel_rn=01 with MEM=5, fwd_sel_rm=10 with WB=9; both sources change the next cycle -> result is 45.
- EARLY_TERM=1, B=1, Rm=3, Rn=10 -> 2 BUSY cycles, result 30. Separately, Rm=0 with S=1 -> result 0, status_out Z=1, N=0.
- freeze held 3 cycles in DONE -> state, busy and outputs hold. On release, valid_out is high for exactly 1 cycle.
- flush at BUSY cycle 5 -> IDLE next cycle, busy=0, no valid_out. Separately, rst low mid-BUSY -> all outputs 0 asynchronously, without waiting for a clk edge.
